bubble_timing_sequencer: RTL and testbench
==========================================

# bubble_timing_sequencer

Parametrised next-generation bubble memory timing generator, derived from the MB14506 emulation already in use. It divides `master_clock` into a sequencer step tick and drives the four-phase rotating-field coil enables. It generates per-channel replicate pulses plus detector clamp and strobe windows, and tracks the absolute bubble loop position. It sits between the bubble host interface (shift and replicator requests) and the page buffer / data-out logic, and supports multiple bubble channels and a controlled stop sequence.

## Interface
- TICK_DIV, 4: `master_clock` cycles per sequencer step (48 MHz / 4 = 12 MHz).
- CLKOUT_HALF, 6: `master_clock` cycles per half period of `clock_out` (4 MHz).
- ROT_STEPS, 120: steps per field rotation; must be a multiple of 4. Q = ROT_STEPS/4.
- OVERLAP, 3: steps of two-coil overlap at the start of each quadrant.
- LEAD_STEPS, 18: coil-off steps between start request and first rotation.
- HOLD_STEPS, 16: steps of -X hold after the last rotation.
- CHANNELS, 2: replicator/detector channels.
- REP_START, 1 and REP_LEN, 3: replicate pulse phases.
- CLAMP_START, 36, STROBE_START, 58 and DET_END, 73: detector window phases.
- POS_WIDTH, 12 and LOOP_LENGTH, 2053: position counter width and wrap value.
- SYNC_STAGES, 3: synchroniser depth.

Ports:
- master_clock  in  1  sole clock.
- reset_n  in  1  reset; synchronous, active-low.
- shift_enable_n  in  1  async; low requests shifting.
- replicator_enable_n  in  CHANNELS  async; low enables replication for that channel.
- position_preset  in  1  loads bubble_position; honoured only in IDLE.
- position_preset_value  in  POS_WIDTH  preset value.
- clock_out  out  1  4 MHz free-running clock.
- coil_drive_n  out  4  HI[+Y -Y -X +X]LO, active-low.
- coil_run  out  1  high while any coil may be driven.
- phase  out  $clog2(ROT_STEPS)  current rotation phase.
- position_change  out  1  one-step pulse at each completed rotation.
- bubble_position  out  POS_WIDTH  loop position.
- replicate_out_n  out  CHANNELS  active-low replicate pulses.
- data_out_notice  out  1  clamp released (detector valid).
- data_out_strobe  out  1  data sample window.

## Operation
- States: IDLE, LEAD, RUN, FINISH, HOLD.
- IDLE:
  - coil_drive_n = 1111, coil_run = 0, phase = 0.
  - A synced shift request moves to LEAD.
- LEAD:
  - Lasts LEAD_STEPS steps with coils off.
  - Transitions to RUN at phase 0.
  - If the request is released during LEAD, return to IDLE at the next step.
- RUN: phase increments each step and wraps ROT_STEPS-1 -> 0.
- Coil pattern. Quadrant k = phase/Q; coil order -X, -Y, +X, +Y.
  - Phases k·Q to k·Q+OVERLAP-1 drive the previous and the current coil.
  - The rest of the quadrant drives the current coil only.
  - Defaults: 0-2 0101, 3-29 1101, 30-32 1001, 33-59 1011, 60-62 1010, 63-89 1110, 90-92 0110, 93-119 0111.
  - The first rotation after LEAD drives 1101 in phases 0-2.
- Wrap to phase 0 (not the first entry from LEAD):
  - position_change pulses for one step.
  - bubble_position increments. LOOP_LENGTH-1 wraps to 0.
- Release of the shift request during RUN goes to FINISH. FINISH completes the current rotation through phase ROT_STEPS-1. A re-request during FINISH returns to RUN without a gap.
- HOLD:
  - Counts wrap as a completed rotation.
  - Drives 1101 for HOLD_STEPS steps, then IDLE.
- coil_run = 1 in RUN, FINISH and HOLD.
- replicator_enable_n is sampled per channel at each phase 0. An enabled channel drives replicate_out_n low for phases REP_START to REP_START+REP_LEN-1. Replicate pulses are only generated in RUN.
- data_out_notice = 1 for phases CLAMP_START to DET_END.
- data_out_strobe = 1 for phases STROBE_START to DET_END.
- Both detector signals are active in RUN and FINISH.
- A preset arriving together with an increment: the preset is ignored (preset is IDLE-only).

## Timing
- All outputs are registered on master_clock.
- Sequencer outputs update on the master_clock edge where the internal step tick is high.
- Input latency: SYNC_STAGES cycles to the synchronised value, plus up to TICK_DIV-1 cycles to the next tick.
- Reset values:
  - coil_drive_n 1111, coil_run 0, phase 0, position_change 0.
  - bubble_position 0, replicate_out_n all 1, data_out_notice 0, data_out_strobe 0.
  - clock_out 1; tick and clock dividers 0.
- Reset asserted mid-operation forces every output to its reset value at the next edge. No HOLD sequence is run.

## Structure
- Package bubble_timing_pkg holds:
  - state enum;
  - coil encoding constants (COIL_OFF 1111, per-coil one-cold masks);
  - coil order array;
  - a function mapping (phase, Q, OVERLAP) to coil_drive_n.
- Sub-module bubble_timing_sync: SYNC_STAGES-deep flop chain, width CHANNELS+1, reset to inactive (all 1).

## Test plan
- Reset: hold reset_n low 5 cycles. Required: all outputs at reset values, and clock_out toggling every 6 cycles after release.
- Single rotation (defaults):
  - Stimulus: shift_enable_n low for exactly 1 rotation.
  - coil_run rises 72 cycles after the synced request.
  - phases follow 1101, 1101, 1001, 1011, 1010, 1110, 0110, 0111.
  - Then 16 steps of 1101, then IDLE.
  - bubble_position increases by 1.
- Replicator: replicator_enable_n = 10, shift held low. replicate_out_n[0] is low for 12 master cycles at phases 1-3 of every rotation; replicate_out_n[1] stays 1.
- Stop mid-rotation: release at phase 50. Coils run to phase 119, hold 1101 for 64 cycles, then coil_run = 0.
- Position wrap: preset 2052 in IDLE, then run 2 rotations. Required: bubble_position = 0, then 1; position_change pulses twice, each 4 cycles wide.
- Reset mid-RUN at phase 40: next edge gives coil_drive_n 1111, coil_run 0, phase 0.

Source files
------------

// File: rtl/bubble_timing_pkg.sv
// ---------------------------------------------------------------------------
// bubble_timing_pkg
//   Shared types and constants for the bubble memory timing sequencer.
//   - state_e      : sequencer state encoding
//   - COIL_*       : coil_drive_n encodings, HI[+Y -Y -X +X]LO, active-low
//   - COIL_ORDER   : coil energised in each quadrant of a field rotation
//   - coil_pattern : maps a rotation phase to the coil_drive_n pattern
// ---------------------------------------------------------------------------
package bubble_timing_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEAD   = 3'd1,
        ST_RUN    = 3'd2,
        ST_FINISH = 3'd3,
        ST_HOLD   = 3'd4
    } state_e;

    // One-cold masks: a 0 bit energises that coil.
    localparam logic [3:0] COIL_OFF = 4'b1111;
    localparam logic [3:0] COIL_PY  = 4'b0111;
    localparam logic [3:0] COIL_MY  = 4'b1011;
    localparam logic [3:0] COIL_MX  = 4'b1101;
    localparam logic [3:0] COIL_PX  = 4'b1110;

    // Quadrant 0..3 energises -X, -Y, +X, +Y in turn.
    localparam logic [3:0] COIL_ORDER [4] = '{COIL_MX, COIL_MY, COIL_PX, COIL_PY};

    // During the first `overlap` phases of a quadrant the previous coil is
    // still held on, so both masks are ANDed (both bits low).
    function automatic logic [3:0] coil_pattern(input int unsigned phase,
                                                input int unsigned q,
                                                input int unsigned overlap);
        int unsigned quad;
        int unsigned offs;
        logic [1:0]  cur_idx;
        logic [1:0]  prev_idx;
        logic [3:0]  result;
        quad     = phase / q;
        offs     = phase - (quad * q);
        cur_idx  = quad[1:0];
        prev_idx = cur_idx - 2'd1;
        result   = COIL_ORDER[cur_idx];
        if (offs < overlap) begin
            result = result & COIL_ORDER[prev_idx];
        end
        return result;
    endfunction

endpackage

// File: rtl/bubble_timing_sync.sv
// ---------------------------------------------------------------------------
// bubble_timing_sync
//   Multi-stage flop synchroniser for the asynchronous host request lines.
//   Ports:
//     clk_i   in  1      clock
//     rst_ni  in  1      synchronous active-low reset (chain resets to '1,
//                        the inactive level of the active-low requests)
//     async_i in  WIDTH  asynchronous inputs
//     sync_o  out WIDTH  synchronised outputs, STAGES cycles of latency
// ---------------------------------------------------------------------------
module bubble_timing_sync
    import bubble_timing_pkg::*;
#(
    parameter int WIDTH  = 3,
    parameter int STAGES = 3
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] async_i,
    output logic [WIDTH-1:0] sync_o
);

    logic [WIDTH-1:0] chain_q [STAGES];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < STAGES; i++) begin
                chain_q[i] <= '1;
            end
        end else begin
            chain_q[0] <= async_i;
            for (int i = 1; i < STAGES; i++) begin
                chain_q[i] <= chain_q[i-1];
            end
        end
    end

    assign sync_o = chain_q[STAGES-1];

endmodule

// File: rtl/bubble_timing_sequencer.sv
// ---------------------------------------------------------------------------
// bubble_timing_sequencer
//   Bubble memory timing generator. Divides master_clock into a sequencer
//   step tick, sequences the four-phase rotating-field coils, generates
//   replicate pulses and detector clamp/strobe windows, and tracks the
//   absolute bubble loop position.
//
//   Ports:
//     master_clock          in  1          sole clock
//     reset_n               in  1          synchronous active-low reset
//     shift_enable_n        in  1          async, low requests shifting
//     replicator_enable_n   in  CHANNELS   async, low enables a channel
//     position_preset       in  1          load bubble_position (IDLE only)
//     position_preset_value in  POS_WIDTH  preset value
//     clock_out             out 1          free-running divided clock
//     coil_drive_n          out 4          HI[+Y -Y -X +X]LO, active-low
//     coil_run              out 1          high while coils may be driven
//     phase                 out clog2(ROT) current rotation phase
//     position_change       out 1          one-step pulse per rotation
//     bubble_position       out POS_WIDTH  loop position
//     replicate_out_n       out CHANNELS   active-low replicate pulses
//     data_out_notice       out 1          clamp released window
//     data_out_strobe       out 1          data sample window
//
//   Every sequencer output is computed from the next state and registered
//   on the edge where the step tick is high, so all of them move together.
// ---------------------------------------------------------------------------
module bubble_timing_sequencer
    import bubble_timing_pkg::*;
#(
    parameter int TICK_DIV     = 4,
    parameter int CLKOUT_HALF  = 6,
    parameter int ROT_STEPS    = 120,
    parameter int OVERLAP      = 3,
    parameter int LEAD_STEPS   = 18,
    parameter int HOLD_STEPS   = 16,
    parameter int CHANNELS     = 2,
    parameter int REP_START    = 1,
    parameter int REP_LEN      = 3,
    parameter int CLAMP_START  = 36,
    parameter int STROBE_START = 58,
    parameter int DET_END      = 73,
    parameter int POS_WIDTH    = 12,
    parameter int LOOP_LENGTH  = 2053,
    parameter int SYNC_STAGES  = 3
) (
    input  logic                         master_clock,
    input  logic                         reset_n,
    input  logic                         shift_enable_n,
    input  logic [CHANNELS-1:0]          replicator_enable_n,
    input  logic                         position_preset,
    input  logic [POS_WIDTH-1:0]         position_preset_value,
    output logic                         clock_out,
    output logic [3:0]                   coil_drive_n,
    output logic                         coil_run,
    output logic [$clog2(ROT_STEPS)-1:0] phase,
    output logic                         position_change,
    output logic [POS_WIDTH-1:0]         bubble_position,
    output logic [CHANNELS-1:0]          replicate_out_n,
    output logic                         data_out_notice,
    output logic                         data_out_strobe
);

    localparam int unsigned Q      = ROT_STEPS / 4;
    localparam int          PH_W   = $clog2(ROT_STEPS);
    localparam int          TD_W   = $clog2(TICK_DIV + 1);
    localparam int          CO_W   = $clog2(CLKOUT_HALF + 1);
    localparam int          CNT_MAX = (LEAD_STEPS > HOLD_STEPS) ? LEAD_STEPS : HOLD_STEPS;
    localparam int          CNT_W  = $clog2(CNT_MAX + 1);

    // ---------------------------------------------------------------
    // Input synchronisation: bit 0 is the shift request, the upper
    // bits are the per-channel replicator enables.
    // ---------------------------------------------------------------
    logic [CHANNELS:0] sync_out;
    logic              shift_req;
    logic [CHANNELS-1:0] rep_en_sync;

    bubble_timing_sync #(
        .WIDTH  (CHANNELS + 1),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i   (master_clock),
        .rst_ni  (reset_n),
        .async_i ({replicator_enable_n, shift_enable_n}),
        .sync_o  (sync_out)
    );

    assign shift_req   = ~sync_out[0];
    assign rep_en_sync = ~sync_out[CHANNELS:1];

    // ---------------------------------------------------------------
    // Step tick and free-running clock_out dividers.
    // ---------------------------------------------------------------
    logic [TD_W-1:0] tick_cnt_q;
    logic            tick;
    logic [CO_W-1:0] clk_cnt_q;
    logic            clock_out_q;

    assign tick = (tick_cnt_q == TD_W'(TICK_DIV - 1));

    always_ff @(posedge master_clock) begin
        if (!reset_n) begin
            tick_cnt_q <= '0;
        end else if (tick) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_q + TD_W'(1);
        end
    end

    always_ff @(posedge master_clock) begin
        if (!reset_n) begin
            clk_cnt_q   <= '0;
            clock_out_q <= 1'b1;
        end else if (clk_cnt_q == CO_W'(CLKOUT_HALF - 1)) begin
            clk_cnt_q   <= '0;
            clock_out_q <= ~clock_out_q;
        end else begin
            clk_cnt_q   <= clk_cnt_q + CO_W'(1);
        end
    end

    // ---------------------------------------------------------------
    // Sequencer state.
    //   first_q : set for the rotation entered from LEAD, where the
    //             previous (+Y) coil was never on, so phases 0..OVERLAP-1
    //             drive -X alone.
    //   rep_en_q: replicator enables latched at each entry to phase 0.
    // ---------------------------------------------------------------
    state_e               state_q,  state_d;
    logic [PH_W-1:0]      phase_q,  phase_d;
    logic [CNT_W-1:0]     cnt_q,    cnt_d;
    logic                 first_q,  first_d;
    logic [POS_WIDTH-1:0] pos_q,    pos_d;
    logic [CHANNELS-1:0]  rep_en_q, rep_en_d;
    logic                 wrap_d;

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        cnt_d    = cnt_q;
        first_d  = first_q;
        pos_d    = pos_q;
        rep_en_d = rep_en_q;
        wrap_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                phase_d = '0;
                // The only place a preset can land, so it never races an
                // increment.
                if (position_preset) begin
                    pos_d = position_preset_value;
                end
                if (shift_req) begin
                    state_d = ST_LEAD;
                    cnt_d   = '0;
                end
            end
            ST_LEAD: begin
                if (!shift_req) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_W'(LEAD_STEPS - 1)) begin
                    state_d  = ST_RUN;
                    phase_d  = '0;
                    first_d  = 1'b1;
                    rep_en_d = rep_en_sync;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RUN, ST_FINISH: begin
                if (phase_q == PH_W'(ROT_STEPS - 1)) begin
                    // Rotation complete: count it whether we continue or
                    // stop. A live request here (including a re-request
                    // during FINISH) continues without a gap.
                    wrap_d  = 1'b1;
                    first_d = 1'b0;
                    phase_d = '0;
                    pos_d   = (pos_q == POS_WIDTH'(LOOP_LENGTH - 1)) ? '0
                                                                     : pos_q + POS_WIDTH'(1);
                    if (shift_req) begin
                        state_d  = ST_RUN;
                        rep_en_d = rep_en_sync;
                    end else begin
                        state_d = ST_HOLD;
                        cnt_d   = '0;
                    end
                end else begin
                    phase_d = phase_q + PH_W'(1);
                    state_d = shift_req ? ST_RUN : ST_FINISH;
                end
            end
            ST_HOLD: begin
                phase_d = '0;
                if (cnt_q == CNT_W'(HOLD_STEPS - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                phase_d = '0;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // Output decode from the next state.
    // ---------------------------------------------------------------
    logic [3:0]          coil_d;
    logic                run_d;
    logic                rotating_d;
    logic                notice_d;
    logic                strobe_d;
    logic                rep_win_d;
    logic [CHANNELS-1:0] rep_n_d;

    always_comb begin
        coil_d     = COIL_OFF;
        run_d      = 1'b0;
        rotating_d = (state_d == ST_RUN) || (state_d == ST_FINISH);
        case (state_d)
            ST_RUN, ST_FINISH: begin
                run_d = 1'b1;
                if (first_d && (phase_d < PH_W'(OVERLAP))) begin
                    coil_d = COIL_MX;
                end else begin
                    coil_d = coil_pattern(32'(phase_d), Q, 32'(OVERLAP));
                end
            end
            ST_HOLD: begin
                run_d  = 1'b1;
                coil_d = COIL_MX;
            end
            default: begin
                coil_d = COIL_OFF;
                run_d  = 1'b0;
            end
        endcase

        notice_d = rotating_d && (phase_d >= PH_W'(CLAMP_START))
                              && (phase_d <= PH_W'(DET_END));
        strobe_d = rotating_d && (phase_d >= PH_W'(STROBE_START))
                              && (phase_d <= PH_W'(DET_END));

        rep_win_d = (state_d == ST_RUN) && (phase_d >= PH_W'(REP_START))
                                        && (phase_d <= PH_W'(REP_START + REP_LEN - 1));
        rep_n_d = '1;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            rep_n_d[ch] = ~(rep_win_d && rep_en_d[ch]);
        end
    end

    // ---------------------------------------------------------------
    // Registers, advanced only on the step tick.
    // ---------------------------------------------------------------
    logic [3:0]          coil_q;
    logic                run_q;
    logic                pc_q;
    logic [CHANNELS-1:0] rep_n_q;
    logic                notice_q;
    logic                strobe_q;

    always_ff @(posedge master_clock) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            phase_q  <= '0;
            cnt_q    <= '0;
            first_q  <= 1'b0;
            pos_q    <= '0;
            rep_en_q <= '0;
            coil_q   <= COIL_OFF;
            run_q    <= 1'b0;
            pc_q     <= 1'b0;
            rep_n_q  <= '1;
            notice_q <= 1'b0;
            strobe_q <= 1'b0;
        end else if (tick) begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            cnt_q    <= cnt_d;
            first_q  <= first_d;
            pos_q    <= pos_d;
            rep_en_q <= rep_en_d;
            coil_q   <= coil_d;
            run_q    <= run_d;
            pc_q     <= wrap_d;
            rep_n_q  <= rep_n_d;
            notice_q <= notice_d;
            strobe_q <= strobe_d;
        end
    end

    assign clock_out       = clock_out_q;
    assign coil_drive_n    = coil_q;
    assign coil_run        = run_q;
    assign phase           = phase_q;
    assign position_change = pc_q;
    assign bubble_position = pos_q;
    assign replicate_out_n = rep_n_q;
    assign data_out_notice = notice_q;
    assign data_out_strobe = strobe_q;

endmodule

// File: tb/tb_bubble_timing_sequencer.sv
// Testbench for bubble_timing_sequencer (default parameters).
module tb_bubble_timing_sequencer;

  localparam int LIMIT = 3000;

  // ---------------- clock / reset ----------------
  logic        master_clock = 1'b0;
  logic        reset_n;
  logic        shift_enable_n;
  logic [1:0]  replicator_enable_n;
  logic        position_preset;
  logic [11:0] position_preset_value;
  logic        clock_out;
  logic [3:0]  coil_drive_n;
  logic        coil_run;
  logic [6:0]  phase;
  logic        position_change;
  logic [11:0] bubble_position;
  logic [1:0]  replicate_out_n;
  logic        data_out_notice;
  logic        data_out_strobe;

  always #5 master_clock = ~master_clock;

  bubble_timing_sequencer dut (
    .master_clock          (master_clock),
    .reset_n               (reset_n),
    .shift_enable_n        (shift_enable_n),
    .replicator_enable_n   (replicator_enable_n),
    .position_preset       (position_preset),
    .position_preset_value (position_preset_value),
    .clock_out             (clock_out),
    .coil_drive_n          (coil_drive_n),
    .coil_run              (coil_run),
    .phase                 (phase),
    .position_change       (position_change),
    .bubble_position       (bubble_position),
    .replicate_out_n       (replicate_out_n),
    .data_out_notice       (data_out_notice),
    .data_out_strobe       (data_out_strobe)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  bit sb_on  = 1'b0;
  int rep_pulses = 0;

  logic [3:0]  exp_coil_q[$];
  int          exp_len_q[$];
  logic [11:0] exp_pos_q[$];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Expected coil segments: value and length in master cycles (0 = unchecked).
  task automatic push_coil(input logic [3:0] v, input int len);
    exp_coil_q.push_back(v);
    exp_len_q.push_back(len);
  endtask

  task automatic push_rotation(input bit first);
    if (first) begin
      push_coil(4'b1101, 120);
    end else begin
      push_coil(4'b0101, 12);
      push_coil(4'b1101, 108);
    end
    push_coil(4'b1001, 12);
    push_coil(4'b1011, 108);
    push_coil(4'b1010, 12);
    push_coil(4'b1110, 108);
    push_coil(4'b0110, 12);
    push_coil(4'b0111, 108);
  endtask

  task automatic push_stop();
    push_coil(4'b1101, 64);
    push_coil(4'b1111, 0);
  endtask

  // ---------------- monitor ----------------
  logic [3:0] prev_coil   = 4'b1111;
  logic       prev_pc     = 1'b0;
  logic       prev_rep0   = 1'b1;
  logic       prev_notice = 1'b0;
  logic       prev_strobe = 1'b0;
  int seg_len  = 0;
  int pend_len = 0;
  int pc_len   = 0;
  int rep_len  = 0;

  always @(negedge master_clock) begin
    logic [3:0] ec;
    int         el;
    if (!sb_on) begin
      pend_len = 0;
    end else begin
      // coil sequence
      if (coil_drive_n !== prev_coil) begin
        if (pend_len > 0) check("coil_seg_len", seg_len, pend_len);
        if (exp_coil_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL coil_unexpected: got %b expected no change", coil_drive_n);
          pend_len = 0;
        end else begin
          ec = exp_coil_q.pop_front();
          el = exp_len_q.pop_front();
          check("coil_value", coil_drive_n, ec);
          check("coil_run_level", coil_run, (ec != 4'b1111));
          pend_len = el;
        end
        seg_len = 1;
      end else begin
        seg_len++;
      end
      // position change pulses
      if (position_change && !prev_pc) begin
        if (exp_pos_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pos_unexpected: got pulse expected none");
        end else begin
          check("pos_value", bubble_position, exp_pos_q.pop_front());
        end
        check("pc_phase", phase, 0);
        pc_len = 1;
      end else if (position_change) begin
        pc_len++;
      end else if (prev_pc) begin
        check("pc_width", pc_len, 4);
      end
      // replicate pulses
      if (!replicate_out_n[0] && prev_rep0) begin
        rep_pulses++;
        rep_len = 1;
        check("rep_phase", phase, 1);
      end else if (!replicate_out_n[0]) begin
        rep_len++;
        check("rep_ch1_idle", replicate_out_n[1], 1'b1);
      end else if (!prev_rep0) begin
        check("rep_width", rep_len, 12);
      end
      // detector windows
      if (data_out_notice && !prev_notice) check("notice_rise_phase", phase, 36);
      if (!data_out_notice && prev_notice) check("notice_fall_phase", phase, 74);
      if (data_out_strobe && !prev_strobe) check("strobe_rise_phase", phase, 58);
      if (!data_out_strobe && prev_strobe) check("strobe_fall_phase", phase, 74);
    end
    prev_coil   = coil_drive_n;
    prev_pc     = position_change;
    prev_rep0   = replicate_out_n[0];
    prev_notice = data_out_notice;
    prev_strobe = data_out_strobe;
  end

  // ---------------- driver tasks ----------------
  task automatic wait_phase(input logic [6:0] p, input string name);
    int n;
    n = 0;
    while (phase !== p && n < LIMIT) begin
      @(negedge master_clock);
      n++;
    end
    check(name, (n < LIMIT), 1'b1);
  endtask

  task automatic wait_run(input logic v, input string name);
    int n;
    n = 0;
    while (coil_run !== v && n < LIMIT) begin
      @(negedge master_clock);
      n++;
    end
    check(name, (n < LIMIT), 1'b1);
  endtask

  task automatic wait_pc(input string name);
    int n;
    n = 0;
    while (position_change !== 1'b1 && n < LIMIT) begin
      @(negedge master_clock);
      n++;
    end
    check(name, (n < LIMIT), 1'b1);
  endtask

  task automatic idle_gap();
    repeat ($urandom_range(3, 9)) @(negedge master_clock);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    logic prev_clk;

    reset_n               = 1'b0;
    shift_enable_n        = 1'b1;
    replicator_enable_n   = 2'b11;
    position_preset       = 1'b0;
    position_preset_value = '0;

    // Reset values
    repeat (5) @(negedge master_clock);
    check("rst_coil", coil_drive_n, 4'b1111);
    check("rst_run", coil_run, 1'b0);
    check("rst_phase", phase, 0);
    check("rst_pc", position_change, 1'b0);
    check("rst_pos", bubble_position, 0);
    check("rst_rep", replicate_out_n, 2'b11);
    check("rst_det", {data_out_notice, data_out_strobe}, 2'b00);
    check("rst_clkout", clock_out, 1'b1);
    reset_n = 1'b1;

    // clock_out half period
    prev_clk = clock_out;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      while (clock_out === prev_clk && n < 20) begin
        @(negedge master_clock);
        n++;
      end
      check("clkout_half", n, 6);
      prev_clk = clock_out;
    end
    idle_gap();

    // Single rotation, released at phase 50
    sb_on = 1'b1;
    push_rotation(1'b1);
    push_stop();
    exp_pos_q.push_back(12'd1);
    shift_enable_n = 1'b0;
    n = 0;
    while (coil_run !== 1'b1 && n < 200) begin
      @(negedge master_clock);
      n++;
    end
    checks++;
    if (n < 76 || n > 79) begin
      errors++;
      $display("FAIL lead_latency: got %0d cycles expected 76..79", n);
    end
    check("run_start_phase", phase, 0);
    wait_phase(7'd50, "wait_phase50_a");
    shift_enable_n = 1'b1;
    wait_run(1'b0, "wait_stop_a");
    idle_gap();
    check("pos_after_one", bubble_position, 1);
    check("idle_phase", phase, 0);

    // Preset in IDLE
    position_preset_value = 12'd2052;
    position_preset       = 1'b1;
    repeat (8) @(negedge master_clock);
    position_preset       = 1'b0;
    @(negedge master_clock);
    check("preset_pos", bubble_position, 2052);

    // Two rotations with channel 0 replicating; wrap 2052 -> 0 -> 1
    replicator_enable_n = 2'b10;
    repeat (10) @(negedge master_clock);
    push_rotation(1'b1);
    push_rotation(1'b0);
    push_stop();
    exp_pos_q.push_back(12'd0);
    exp_pos_q.push_back(12'd1);
    shift_enable_n = 1'b0;
    wait_run(1'b1, "wait_run_b");
    wait_phase(7'd10, "wait_phase10_b");
    // A preset outside IDLE must be ignored.
    position_preset_value = 12'd5;
    position_preset       = 1'b1;
    repeat (8) @(negedge master_clock);
    position_preset       = 1'b0;
    wait_pc("wait_pc_b");
    wait_phase(7'd50, "wait_phase50_b");
    shift_enable_n = 1'b1;
    wait_run(1'b0, "wait_stop_b");
    idle_gap();
    check("pos_after_wrap", bubble_position, 1);
    check("rep_pulse_count", rep_pulses, 2);
    replicator_enable_n = 2'b11;
    idle_gap();

    // Reset mid-RUN at phase 40
    sb_on = 1'b0;
    shift_enable_n = 1'b0;
    wait_run(1'b1, "wait_run_c");
    wait_phase(7'd40, "wait_phase40_c");
    reset_n = 1'b0;
    @(negedge master_clock);
    check("midrst_coil", coil_drive_n, 4'b1111);
    check("midrst_run", coil_run, 1'b0);
    check("midrst_phase", phase, 0);
    check("midrst_pos", bubble_position, 0);
    check("midrst_det", {data_out_notice, data_out_strobe}, 2'b00);
    shift_enable_n = 1'b1;
    repeat (3) @(negedge master_clock);
    reset_n = 1'b1;
    repeat (10) @(negedge master_clock);
    check("post_rst_run", coil_run, 1'b0);

    // Final report
    check("coil_q_drained", exp_coil_q.size(), 0);
    check("pos_q_drained", exp_pos_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
